// File: rtl/mult_fu_pipe_if.sv
// Issue/result handshake bundle between issue select, the multiply unit and the CDB arbiter.
// master = issue/CDB side, slave = multiply functional unit.
interface mult_fu_pipe_if #(
   parameter int unsigned PR_W = 6
);
   logic            in_valid;
   logic [1:0]      in_func;
   logic [31:0]     in_opa;
   logic [31:0]     in_opb;
   logic [PR_W-1:0] in_dest_pr;
   logic            cdb_grant;
   logic            fu_ready;
   logic            out_valid;
   logic [PR_W-1:0] out_dest_pr;
   logic [31:0]     out_result;

   modport master (
      output in_valid, in_func, in_opa, in_opb, in_dest_pr, cdb_grant,
      input  fu_ready, out_valid, out_dest_pr, out_result
   );

   modport slave (
      input  in_valid, in_func, in_opa, in_opb, in_dest_pr, cdb_grant,
      output fu_ready, out_valid, out_dest_pr, out_result
   );
endinterface

// File: rtl/mult_fu_pipe.sv
// Pipelined RV32M multiply unit: shift-add over STAGES stages, result held until CDB grant.
// Each stage retires 64/STAGES multiplier bits; the whole pipe freezes while a held result waits.
module mult_fu_pipe #(
   parameter int unsigned STAGES = 4,
   parameter int unsigned PR_W   = 6
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          flush,
   mult_fu_pipe_if.slave fu
);

   localparam int unsigned STEP_BITS = 64 / STAGES;
   localparam int unsigned LAST      = STAGES - 1;

   typedef enum logic [1:0] {
      F_MUL    = 2'b00,
      F_MULH   = 2'b01,
      F_MULHSU = 2'b10,
      F_MULHU  = 2'b11
   } func_e;

   typedef struct packed {
      logic [63:0] acc;
      logic [63:0] mcand;
      logic [63:0] mplier;
   } mstate_t;

   // Consume STEP_BITS multiplier bits, LSB first; all arithmetic is mod 2^64.
   function automatic mstate_t step(input mstate_t s);
      mstate_t r;
      r = s;
      for (int unsigned i = 0; i < STEP_BITS; i++) begin
         if (r.mplier[0]) begin
            r.acc = r.acc + r.mcand;
         end
         r.mcand  = r.mcand << 1;
         r.mplier = r.mplier >> 1;
      end
      return r;
   endfunction

   mstate_t         st_q    [STAGES];
   mstate_t         st_d    [STAGES];
   func_e           func_q  [STAGES];
   logic [PR_W-1:0] dest_q  [STAGES];
   logic [STAGES-1:0] vld_q;

   func_e       in_func_e;
   logic        sign_a;
   logic        sign_b;
   mstate_t     in_state;
   logic        stall;
   logic [31:0] sel_result;

   always_comb begin
      in_func_e = func_e'(fu.in_func);
      sign_a    = (in_func_e == F_MULH) || (in_func_e == F_MULHSU);
      sign_b    = (in_func_e == F_MULH);
      in_state.acc    = '0;
      in_state.mcand  = {{32{sign_a & fu.in_opa[31]}}, fu.in_opa};
      in_state.mplier = {{32{sign_b & fu.in_opb[31]}}, fu.in_opb};
   end

   always_comb begin
      stall       = fu.out_valid & ~fu.cdb_grant;
      fu.fu_ready = ~stall;
   end

   always_comb begin
      st_d[0] = step(in_state);
      for (int unsigned k = 1; k < STAGES; k++) begin
         st_d[k] = step(st_q[k-1]);
      end
   end

   always_comb begin
      sel_result = (func_q[LAST] == F_MUL) ? st_q[LAST].acc[31:0] : st_q[LAST].acc[63:32];
   end

   // Valid bits: flush beats stall/grant; data fields below only follow the stall enable.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         vld_q        <= '0;
         fu.out_valid <= 1'b0;
      end else if (flush) begin
         vld_q        <= '0;
         fu.out_valid <= 1'b0;
      end else if (!stall) begin
         vld_q[0] <= fu.in_valid;
         for (int unsigned k = 1; k < STAGES; k++) begin
            vld_q[k] <= vld_q[k-1];
         end
         fu.out_valid <= vld_q[LAST];
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            st_q[k]   <= '0;
            func_q[k] <= F_MUL;
            dest_q[k] <= '0;
         end
         fu.out_dest_pr <= '0;
         fu.out_result  <= '0;
      end else if (!stall) begin
         st_q[0]   <= st_d[0];
         func_q[0] <= in_func_e;
         dest_q[0] <= fu.in_dest_pr;
         for (int unsigned k = 1; k < STAGES; k++) begin
            st_q[k]   <= st_d[k];
            func_q[k] <= func_q[k-1];
            dest_q[k] <= dest_q[k-1];
         end
         fu.out_dest_pr <= dest_q[LAST];
         fu.out_result  <= sel_result;
      end
   end

endmodule

// File: tb/tb_mult_fu_pipe.sv
// Scoreboard bench for mult_fu_pipe: issue pushes expected results, a negedge monitor
// pops and compares each result as it is granted onto the CDB.
module tb_mult_fu_pipe;

   localparam int unsigned PR_W = 6;

   logic clock = 1'b0;
   logic reset;
   logic flush;

   always #5 clock = ~clock;

   mult_fu_pipe_if #(.PR_W(PR_W)) fu ();

   mult_fu_pipe #(.STAGES(4), .PR_W(PR_W)) dut (
      .clock (clock),
      .reset (reset),
      .flush (flush),
      .fu    (fu)
   );

   typedef struct {
      logic [31:0]     res;
      logic [PR_W-1:0] dest;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   // Scoreboard monitor: a result retires at the edge following a negedge with valid & grant.
   always @(negedge clock) begin
      if (reset === 1'b1 && flush === 1'b0 && fu.out_valid === 1'b1 && fu.cdb_grant === 1'b1) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_result: got dest %0d result %h expected none", fu.out_dest_pr, fu.out_result);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (fu.out_result !== e.res || fu.out_dest_pr !== e.dest) begin
               n_fail++;
               $display("FAIL result: got dest %0d result %h expected dest %0d result %h",
                        fu.out_dest_pr, fu.out_result, e.dest, e.res);
            end
         end
      end
   end

   // Issue protocol: never present in_valid while the unit reports not ready.
   always @(negedge clock) begin
      if (reset === 1'b1 && fu.in_valid === 1'b1) begin
         n_checks++;
         if (fu.fu_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL issue_protocol: in_valid with fu_ready=%b expected 1", fu.fu_ready);
         end
      end
   end

   // Called at posedge+1; waits (bounded) for fu_ready, issues for one edge, returns at posedge+1.
   task automatic issue(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [PR_W-1:0] d, input logic [31:0] res, input bit push);
      int guard;
      guard = 0;
      fu.in_valid = 1'b0;
      while (fu.fu_ready !== 1'b1 && guard < 100) begin
         @(posedge clock); #1;
         guard++;
      end
      if (fu.fu_ready !== 1'b1) begin
         chk("issue_ready_timeout", {63'd0, fu.fu_ready}, 64'd1);
      end
      fu.in_valid   = 1'b1;
      fu.in_func    = f;
      fu.in_opa     = a;
      fu.in_opb     = b;
      fu.in_dest_pr = d;
      if (push) begin
         exp_t e;
         e.res  = res;
         e.dest = d;
         exp_q.push_back(e);
      end
      @(posedge clock); #1;
      fu.in_valid = 1'b0;
   endtask

   // Single op into an empty pipe with grant held: out_valid exactly on edge N+4.
   task automatic single_latency(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                                 input logic [PR_W-1:0] d, input logic [31:0] res);
      issue(f, a, b, d, res, 1'b1);
      chk("latency_edge0", {63'd0, fu.out_valid}, 64'd0);
      for (int k = 1; k <= 5; k++) begin
         @(posedge clock); #1;
         chk($sformatf("latency_edge%0d", k), {63'd0, fu.out_valid}, (k == 4) ? 64'd1 : 64'd0);
      end
   endtask

   task automatic wait_drain();
      int guard;
      guard = 0;
      while ((exp_q.size() != 0 || fu.out_valid === 1'b1) && guard < 60) begin
         @(posedge clock); #1;
         guard++;
      end
      chk("drain", {32'd0, exp_q.size()}, 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset         = 1'b0;
      flush         = 1'b0;
      fu.in_valid   = 1'b0;
      fu.in_func    = 2'b00;
      fu.in_opa     = '0;
      fu.in_opb     = '0;
      fu.in_dest_pr = '0;
      fu.cdb_grant  = 1'b1;

      repeat (2) @(posedge clock);
      #1;
      chk("reset_out_valid", {63'd0, fu.out_valid}, 64'd0);
      chk("reset_out_dest", {58'd0, fu.out_dest_pr}, 64'd0);
      chk("reset_out_result", {32'd0, fu.out_result}, 64'd0);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock); #1;
      chk("reset_fu_ready", {63'd0, fu.fu_ready}, 64'd1);

      // Basic MUL with latency and one-cycle grant retirement.
      single_latency(2'b00, 32'd7, 32'hFFFF_FFFD, 6'd5, 32'hFFFF_FFEB);
      wait_drain();

      // Directed vectors across all four functions.
      issue(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd10, 32'hFFFF_FFFE, 1'b1);
      issue(2'b01, 32'h8000_0000, 32'h8000_0000, 6'd11, 32'h4000_0000, 1'b1);
      issue(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd12, 32'hFFFF_FFFF, 1'b1);
      issue(2'b00, 32'h8000_0000, 32'h8000_0000, 6'd13, 32'h0000_0000, 1'b1);
      issue(2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 6'd14, 32'hFFFF_FFFF, 1'b1);
      issue(2'b11, 32'hFFFF_FFFF, 32'h0000_0002, 6'd15, 32'h0000_0001, 1'b1);
      issue(2'b10, 32'h0000_0002, 32'hFFFF_FFFF, 6'd16, 32'h0000_0001, 1'b1);
      issue(2'b00, 32'h1234_5678, 32'h0000_0010, 6'd17, 32'h2345_6780, 1'b1);
      issue(2'b01, 32'd7, 32'hFFFF_FFFD, 6'd18, 32'hFFFF_FFFF, 1'b1);
      wait_drain();

      // Throughput: six back-to-back with grant held high.
      fork
         begin
            for (int i = 1; i <= 6; i++) begin
               issue(2'b00, i, i, i[PR_W-1:0], i * i, 1'b1);
            end
         end
         begin
            int guard;
            int run;
            guard = 0;
            run   = 0;
            @(negedge clock);
            while (fu.out_valid !== 1'b1 && guard < 20) begin
               @(negedge clock);
               guard++;
            end
            while (fu.out_valid === 1'b1 && run < 20) begin
               run++;
               @(negedge clock);
            end
            chk("throughput_run", run, 64'd6);
         end
      join
      wait_drain();

      // Backpressure: grant low until the pipe fills, then release.
      fu.cdb_grant = 1'b0;
      fork
         begin
            for (int i = 1; i <= 6; i++) begin
               issue(2'b00, i + 1, 32'd3, (i + 20), (i + 1) * 3, 1'b1);
            end
         end
         begin
            int guard;
            guard = 0;
            while (fu.out_valid !== 1'b1 && guard < 20) begin
               @(posedge clock); #1;
               guard++;
            end
            chk("bp_ready_low", {63'd0, fu.fu_ready}, 64'd0);
            for (int k = 0; k < 3; k++) begin
               @(posedge clock); #1;
               chk("bp_hold_valid", {63'd0, fu.out_valid}, 64'd1);
               chk("bp_hold_dest", {58'd0, fu.out_dest_pr}, 64'd21);
            end
            fu.cdb_grant = 1'b1;
         end
      join
      wait_drain();

      // Flush on the cycle of the third issue: nothing emerges.
      issue(2'b00, 32'd9, 32'd9, 6'd30, 32'd0, 1'b0);
      issue(2'b00, 32'd8, 32'd8, 6'd31, 32'd0, 1'b0);
      flush = 1'b1;
      issue(2'b00, 32'd7, 32'd7, 6'd32, 32'd0, 1'b0);
      flush = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clock);
         chk("flush_quiet", {63'd0, fu.out_valid}, 64'd0);
      end
      @(posedge clock); #1;
      single_latency(2'b11, 32'h0001_0000, 32'h0003_0000, 6'd33, 32'h0000_0003);
      wait_drain();

      // Asynchronous reset while a result is held.
      fu.cdb_grant = 1'b0;
      issue(2'b00, 32'd6, 32'd7, 6'd40, 32'd0, 1'b0);
      begin
         int guard;
         guard = 0;
         while (fu.out_valid !== 1'b1 && guard < 20) begin
            @(posedge clock); #1;
            guard++;
         end
         chk("areset_held", {63'd0, fu.out_valid}, 64'd1);
      end
      #2;
      reset = 1'b0;
      #1;
      chk("areset_out_valid", {63'd0, fu.out_valid}, 64'd0);
      chk("areset_out_result", {32'd0, fu.out_result}, 64'd0);
      chk("areset_out_dest", {58'd0, fu.out_dest_pr}, 64'd0);
      @(negedge clock); #2;
      reset = 1'b1;
      fu.cdb_grant = 1'b1;
      @(posedge clock); #1;
      chk("areset_fu_ready", {63'd0, fu.fu_ready}, 64'd1);
      single_latency(2'b00, 32'd6, 32'd7, 6'd41, 32'd42);
      wait_drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
